// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    localparam int MULT_WIDTH = 8;

endpackage

// File: rtl/module_mult_dp.sv
// Shift-add datapath: multiplicand/multiplier shifters, accumulator and iteration counter.
module module_mult_dp
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 shift,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 cnt_last,
    output logic [2*WIDTH-1:0]   acc_next
);

    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic [CW-1:0]      cnt;

    // acc_next includes the current iteration's add so the top can latch
    // the final product on the last shift edge without an extra cycle.
    assign acc_next = acc + (mplier[0] ? mcand : '0);
    assign cnt_last = (cnt == CW'(1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= CW'(WIDTH);
        end else if (shift) begin
            acc    <= acc_next;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/module_mult_seq.sv
// Sequential multiplier top: control FSM, busy/done decode and the product register.
module module_mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   prod
);

    mult_state_t        state;
    logic               load;
    logic               shift;
    logic               cnt_last;
    logic [2*WIDTH-1:0] acc_next;

    // Operands are only captured on the IDLE->CALC edge; start elsewhere is dropped.
    assign load  = (state == IDLE) && start;
    assign shift = (state == CALC);
    assign busy  = (state == CALC);
    assign done  = (state == DONE);

    module_mult_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .a        (a),
        .b        (b),
        .cnt_last (cnt_last),
        .acc_next (acc_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            prod  <= '0;
        end else begin
            case (state)
                IDLE: if (start) state <= CALC;
                CALC: begin
                    if (cnt_last) begin
                        prod  <= acc_next;
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
